led_blink_arbiter: RTL and testbench
====================================

# led_blink_arbiter

Shares the board's single status LED among several requesters, each wanting to flash a short blink code. A round-robin arbiter grants the LED to one requester at a time. A tick-driven state machine then plays that requester's pulse count, followed by a fixed dark gap, and releases the LED. It sits between status-producing blocks and the top-level `led` pin, replacing a free-running divider blinker.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TICK_DIV`, 12500000: clk cycles per tick (10 Hz at 125 MHz); minimum 2.
- `GAP_TICKS`, 4: dark ticks appended after each code; minimum 1.

- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input NUM_REQ: level request per requester.
- `code` input 4*NUM_REQ: blink count per requester; requester i uses bits [4i+3:4i].
- `grant` output NUM_REQ: one-hot owner of the LED; zero when idle.
- `done` output 1: one-cycle pulse when a grant ends.
- `led` output 1: LED drive.

## Operation
- Prescaler `pcnt` counts 0..TICK_DIV-1 and wraps.
- `tick` is high while `pcnt == TICK_DIV-1`.
- `pcnt` is forced to 0 in the cycle a grant is issued.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - Evaluated every cycle, not only on tick.
  - If `req` is nonzero, pick the first set bit searching upward from `last+1` with wrap.
  - Then set `last` to the winner, latch `code` of the winner into `remain`, and set `grant`.
  - Next state is ON if the latched code is nonzero, otherwise GAP.
- ON:
  - `led=1`.
  - On tick go to OFF.
- OFF:
  - `led=0`.
  - On tick decrement `remain`.
  - Go to ON if the new `remain` is nonzero, otherwise GAP with `gcnt=GAP_TICKS-1`.
- GAP:
  - `led=0`.
  - On tick: if `gcnt==0`, go to IDLE, clear `grant` and pulse `done`; otherwise decrement `gcnt`.
- Inputs are sampled only at grant time:
  - Deasserting `req` mid-sequence does not abort the sequence.
  - Changes to `code` mid-sequence are ignored.
- A requester still requesting at release re-enters arbitration and loses to any other requester that is waiting.
- `remain` is 4 bits; codes 1..15 produce 1..15 pulses.
- Reset values:
  - Outputs: `grant=0`, `done=0`, `led=0`.
  - State is IDLE, `pcnt=0`, `last=NUM_REQ-1`, so requester 0 wins first.
- Asserting reset mid-sequence clears everything immediately and asynchronously. No partial sequence resumes.

## Timing
- All outputs are registered.
- Request latency: `req` sampled high in IDLE at cycle N gives `grant` and `led` valid from cycle N+1.
- Grant length is (2·code + GAP_TICKS)·TICK_DIV cycles. Each ON and OFF phase lasts exactly TICK_DIV cycles.
- `done` is high in the first IDLE cycle after a grant, with `grant=0`.
- That same cycle arbitrates, so back-to-back grants have exactly one idle cycle between them.
- Single-cycle `req` pulses are honored if they coincide with an IDLE cycle.

## Configuration
- `LED_BLINK_IDLE_HEARTBEAT_EN`
  - Defined: in IDLE, `led` follows heartbeat register `hb`, which toggles on every tick while idle. `hb` resets to 0 and is held at 0 during grants.
  - Undefined: `led=0` throughout IDLE and no `hb` register exists.
- All other behaviour is identical with and without the macro.

## Test plan
All scenarios use `TICK_DIV=4`, `GAP_TICKS=2`, `NUM_REQ=4`, with the macro undefined unless stated.

- **Reset:** hold `rst_n=0` with `req=4'b1111` → `grant=0`, `done=0`, `led=0`. After release, first grant is `4'b0001`.
- **Single request:** `req[0]=1`, code 3, sampled at cycle 0 → `grant=4'b0001` for cycles 1..32. `led` high for cycles 1-4, 9-12 and 17-20, low elsewhere. `done=1` at cycle 33 only.
- **Round-robin fairness:** `req=4'b1111`, all codes 1 → grants in order 0, 1, 2, 3, 0. Each grant lasts 16 cycles, with a 1-cycle `done` gap between grants.
- **Zero code:** code 0 on requester 2 → `grant=4'b0100` for 8 cycles, `led` never high, then `done`.
- **Request withdrawn:** drop `req[1]` two cycles after its grant, code 2 → full 24-cycle sequence still plays, then `done`.
- **Reset mid-sequence and heartbeat:**
  - Assert `rst_n=0` during an ON phase → `led` and `grant` fall within the same cycle.
  - With `LED_BLINK_IDLE_HEARTBEAT_EN` defined and no requests → `led` toggles every 4 cycles.

Source files
------------

// File: rtl/led_blink_arbiter.sv
// Round-robin owner of the single status LED: plays the winner's blink count, a dark gap, then
// releases. Optional idle heartbeat on the LED when LED_BLINK_IDLE_HEARTBEAT_EN is defined.
module led_blink_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TICK_DIV  = 12500000,
    parameter int unsigned GAP_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] code,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 done,
    output logic                 led
);

    localparam int unsigned LW = $clog2(NUM_REQ);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        pcnt_q, pcnt_d;
    logic [LW-1:0]        last_q, last_d;
    logic [3:0]           remain_q, remain_d;
    logic [GW-1:0]        gcnt_q, gcnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 done_q, done_d;
    logic                 led_q, led_d;
`ifdef LED_BLINK_IDLE_HEARTBEAT_EN
    logic                 hb_q, hb_d;
`endif

    logic                 tick;
    logic                 found;
    logic [LW-1:0]        win;
    logic [LW:0]          cand;
    logic [3:0]           win_code;
    logic                 release_now;

    assign tick = (pcnt_q == PW'(TICK_DIV - 1));

    // Rotating priority: search upward from the slot after the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = {1'b0, last_q} + (LW+1)'(k);
            if (cand >= (LW+1)'(NUM_REQ)) begin
                cand = cand - (LW+1)'(NUM_REQ);
            end
            if (!found && req[cand[LW-1:0]]) begin
                found = 1'b1;
                win   = cand[LW-1:0];
            end
        end
    end

    assign win_code    = code[{win, 2'b00} +: 4];
    assign release_now = (state_q == StGap) && tick && (gcnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pcnt_q   <= '0;
            last_q   <= LW'(NUM_REQ - 1);
            remain_q <= '0;
            gcnt_q   <= '0;
            grant_q  <= '0;
            done_q   <= 1'b0;
            led_q    <= 1'b0;
`ifdef LED_BLINK_IDLE_HEARTBEAT_EN
            hb_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            last_q   <= last_d;
            remain_q <= remain_d;
            gcnt_q   <= gcnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            led_q    <= led_d;
`ifdef LED_BLINK_IDLE_HEARTBEAT_EN
            hb_q     <= hb_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
        last_d   = last_q;
        remain_d = remain_q;
        gcnt_d   = gcnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    // Restart the prescaler so the first phase is a full tick long.
                    pcnt_d   = '0;
                    last_d   = win;
                    remain_d = win_code;
                    gcnt_d   = GW'(GAP_TICKS - 1);
                    state_d  = (win_code != 4'd0) ? StOn : StGap;
                end
            end
            StOn: begin
                if (tick) begin
                    state_d = StOff;
                end
            end
            StOff: begin
                if (tick) begin
                    remain_d = remain_q - 4'd1;
                    if (remain_d != 4'd0) begin
                        state_d = StOn;
                    end else begin
                        state_d = StGap;
                        gcnt_d  = GW'(GAP_TICKS - 1);
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    if (gcnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        gcnt_d = gcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic, computed one cycle ahead so every output leaves a flop.
    always_comb begin
        grant_d = grant_q;
        done_d  = 1'b0;
        if ((state_q == StIdle) && found) begin
            grant_d = NUM_REQ'(1) << win;
        end
        if (release_now) begin
            grant_d = '0;
            done_d  = 1'b1;
        end
`ifdef LED_BLINK_IDLE_HEARTBEAT_EN
        hb_d = 1'b0;
        if ((state_q == StIdle) && !found) begin
            hb_d = hb_q ^ tick;
        end
        led_d = (state_d == StOn) || hb_d;
`else
        led_d = (state_d == StOn);
`endif
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed plus randomized bench for led_blink_arbiter with TICK_DIV=4, GAP_TICKS=2, NUM_REQ=4.
module tb_led_blink_arbiter;

    localparam int TD = 4;
    localparam int GT = 2;
    localparam int NR = 4;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [4*NR-1:0] code;
    logic [NR-1:0] grant;
    logic          done;
    logic          led;

    int n_assert;
    int n_fail;

    led_blink_arbiter #(
        .NUM_REQ  (NR),
        .TICK_DIV (TD),
        .GAP_TICKS(GT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .code (code),
        .grant(grant),
        .done (done),
        .led  (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: cycle t (1-based) of a grant falls in tick phase (t-1)/TD; phases alternate
    // ON/OFF for 2*c phases, then the gap.
    function automatic bit led_exp(input int t, input int c);
        int p;
        p = (t - 1) / TD;
        return (p < 2 * c) && (p % 2 == 0);
    endfunction

    function automatic int pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // mode 0: hold inputs, 1: drop req two cycles in, 2: scramble req/code every cycle
    task automatic run_grant(input int who, input int c, input int mode);
        int len;
        len = (2 * c + GT) * TD;
        for (int t = 1; t <= len; t++) begin
            @(negedge clk);
            chk($sformatf("grant[w%0d t%0d]", who, t), 32'(grant), 32'(1 << who));
            chk($sformatf("led[w%0d c%0d t%0d]", who, c, t), 32'(led), 32'(led_exp(t, c)));
            chk($sformatf("done_low[t%0d]", t), 32'(done), 32'd0);
            if (mode == 1 && t == 2) req = '0;
            if (mode == 2) begin
                req  = 4'($urandom);
                code = 16'($urandom);
            end
        end
        @(negedge clk);
        chk($sformatf("done_pulse[w%0d]", who), 32'(done), 32'd1);
        chk($sformatf("grant_release[w%0d]", who), 32'(grant), 32'd0);
        chk($sformatf("led_release[w%0d]", who), 32'(led), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
`ifndef LED_BLINK_IDLE_HEARTBEAT_EN
            chk("idle_led", 32'(led), 32'd0);
`endif
        end
    endtask

    initial begin
        logic [NR-1:0]   r;
        logic [4*NR-1:0] cv;
        int              last_m;
        int              who;
        int              c;

        n_assert = 0;
        n_fail   = 0;

        // Reset held with all requests pending
        rst_n = 1'b0;
        req   = 4'b1111;
        code  = 16'h1111;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        rst_n = 1'b1;

        // Round robin, all codes 1: 0,1,2,3,0
        run_grant(0, 1, 0);
        run_grant(1, 1, 0);
        run_grant(2, 1, 0);
        run_grant(3, 1, 0);
        run_grant(0, 1, 0);

        // Single request, code 3
        req  = 4'b0001;
        code = 16'h0003;
        run_grant(0, 3, 0);

        // Zero code on requester 2
        req  = 4'b0100;
        code = 16'h0000;
        run_grant(2, 0, 0);

        // Requester 1 withdraws two cycles in, code 2
        req  = 4'b0010;
        code = 16'h0020;
        run_grant(1, 2, 1);

        // Reset during an ON phase
        req  = 4'b1000;
        code = 16'h3000;
        @(negedge clk);
        chk("mid_grant_pre", 32'(grant), 32'h8);
        chk("mid_led_pre", 32'(led), 32'd1);
        @(negedge clk);
        chk("mid_led_on", 32'(led), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_led", 32'(led), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        req  = '0;
        code = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle LED after reset: heartbeat toggles every TD cycles when enabled, else dark
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("idle_grant[k%0d]", k), 32'(grant), 32'd0);
`ifdef LED_BLINK_IDLE_HEARTBEAT_EN
            chk($sformatf("hb_led[k%0d]", k), 32'(led), 32'((k / TD) % 2));
`else
            chk($sformatf("idle_led[k%0d]", k), 32'(led), 32'd0);
`endif
        end

        // No partial sequence resumes: arbitration pointer is back at requester 0
        req  = 4'b1111;
        code = 16'h2222;
        run_grant(0, 2, 0);

        // Randomized traffic against the reference arbiter, inputs scrambled mid-grant
        last_m = 0;
        for (int it = 0; it < 16; it++) begin
            r  = 4'($urandom_range(0, 15));
            cv = '0;
            for (int i = 0; i < NR; i++) cv[4*i +: 4] = 4'($urandom_range(0, 5));
            req  = r;
            code = cv;
            if (r == '0) begin
                idle_cycles(1 + $urandom_range(0, 3));
                r   = 4'($urandom_range(1, 15));
                req = r;
            end
            who    = pick(r, last_m);
            last_m = who;
            c      = int'(cv[4*who +: 4]);
            run_grant(who, c, 2);
        end

        req  = '0;
        code = '0;
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
